// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive FIFO between the UART receiver and the register file.
// Holds {data[7:0], break, parity_err, framing_err} records. The head record is
// shown ahead on data_out, and an RBR read pops it. Fill count, sticky overrun
// and an "error anywhere in FIFO" flag are provided for LSR bits 1 and 7.
// Optional feature: define UART_RX_FIFO_TRIG_EN to add trig_sel/trig_hit.
// Ports:
//   clk, wb_rst_i (async, active-high)
//   data_in, push, pop          record input, push strobe, pop strobe (RBR read)
//   fifo_reset, reset_status    synchronous flush, synchronous overrun clear
//   data_out, count, full, empty, overrun, error_bit
//   trig_sel, trig_hit          (UART_RX_FIFO_TRIG_EN only) fill-level trigger
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             wb_rst_i,
  input  logic [WIDTH-1:0] data_in,
  input  logic             push,
  input  logic             pop,
  input  logic             fifo_reset,
  input  logic             reset_status,
`ifdef UART_RX_FIFO_TRIG_EN
  input  logic [1:0]       trig_sel,
  output logic             trig_hit,
`endif
  output logic [WIDTH-1:0] data_out,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             overrun,
  output logic             error_bit
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wp, rp;
  logic [CNT_W-1:0] err_cnt, cnt_nxt, err_nxt;
  logic [WIDTH-1:0] head;
  logic             do_push, do_pop, ovr_set, push_err, pop_err;

  assign head     = mem[rp];
  assign data_out = (count != '0) ? head : '0;

  // Accept/reject decisions; a flush overrides everything else this cycle.
  always_comb begin
    do_pop   = 1'b0;
    do_push  = 1'b0;
    ovr_set  = 1'b0;
    push_err = 1'b0;
    pop_err  = 1'b0;
    cnt_nxt  = count;
    err_nxt  = err_cnt;
    if (fifo_reset) begin
      cnt_nxt = '0;
      err_nxt = '0;
    end else begin
      do_pop   = pop && (count != '0);
      // A pop frees the slot, so push+pop on a full FIFO is accepted.
      do_push  = push && ((count != FULL_CNT) || do_pop);
      ovr_set  = push && (count == FULL_CNT) && !pop;
      push_err = do_push && (|data_in[2:0]);
      pop_err  = do_pop && (|head[2:0]);
      if (do_push && !do_pop)      cnt_nxt = count + CNT_W'(1);
      else if (do_pop && !do_push) cnt_nxt = count - CNT_W'(1);
      if (push_err && !pop_err)      err_nxt = err_cnt + CNT_W'(1);
      else if (pop_err && !push_err) err_nxt = err_cnt - CNT_W'(1);
    end
  end

  // Storage array, not reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= data_in;
  end

  // Pointers, counters and registered flags.
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      err_cnt   <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      overrun   <= 1'b0;
      error_bit <= 1'b0;
    end else begin
      if (fifo_reset) begin
        wp <= '0;
        rp <= '0;
      end else begin
        if (do_push) wp <= wp + PTR_W'(1);
        if (do_pop)  rp <= rp + PTR_W'(1);
      end
      count     <= cnt_nxt;
      err_cnt   <= err_nxt;
      full      <= (cnt_nxt == FULL_CNT);
      empty     <= (cnt_nxt == '0);
      error_bit <= (err_nxt != '0);
      // Set beats clear; flush beats both.
      if (fifo_reset)        overrun <= 1'b0;
      else if (ovr_set)      overrun <= 1'b1;
      else if (reset_status) overrun <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_TRIG_EN
  logic [CNT_W-1:0] level;

  // Trigger thresholds 1/4/8/14.
  always_comb begin
    level = CNT_W'(1);
    case (trig_sel)
      2'b00: level = CNT_W'(1);
      2'b01: level = CNT_W'(4);
      2'b10: level = CNT_W'(8);
      2'b11: level = CNT_W'(14);
      default: level = CNT_W'(1);
    endcase
  end

  // Evaluated on the next count so it tracks count cycle for cycle.
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i)        trig_hit <= 1'b0;
    else if (fifo_reset) trig_hit <= 1'b0;
    else                 trig_hit <= (cnt_nxt >= level);
  end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: directed scenarios plus randomized traffic,
// compared against a queue-based model of the FIFO contents.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic [10:0] data_in = '0;
  logic        push = 1'b0, pop = 1'b0, fifo_reset = 1'b0, reset_status = 1'b0;
  logic [10:0] data_out;
  logic [4:0]  count;
  logic        full, empty, overrun, error_bit;
`ifdef UART_RX_FIFO_TRIG_EN
  logic [1:0]  trig_sel = 2'b00;
  logic        trig_hit;
`endif

  int n_checks = 0;
  int n_fail = 0;

  // Model state: queue of held records plus the sticky overrun bit.
  logic [10:0] mq[$];
  logic        movr = 1'b0;

  uart_rx_fifo dut (
    .clk(clk), .wb_rst_i(wb_rst_i), .data_in(data_in), .push(push), .pop(pop),
    .fifo_reset(fifo_reset), .reset_status(reset_status),
`ifdef UART_RX_FIFO_TRIG_EN
    .trig_sel(trig_sel), .trig_hit(trig_hit),
`endif
    .data_out(data_out), .count(count), .full(full), .empty(empty),
    .overrun(overrun), .error_bit(error_bit)
  );

  always #5 clk = ~clk;

  function automatic void model_step(input logic ps, input logic pp, input logic [10:0] d,
                                     input logic fr, input logic rs);
    logic set;
    if (fr) begin
      mq.delete();
      movr = 1'b0;
      return;
    end
    set = ps && (mq.size() == DEPTH) && !pp;
    if (rs)  movr = 1'b0;
    if (set) movr = 1'b1;
    if (pp && mq.size() != 0) void'(mq.pop_front());
    if (ps && !set) mq.push_back(d);
  endfunction

  function automatic logic [10:0] exp_head();
    return (mq.size() != 0) ? mq[0] : 11'h000;
  endfunction

  function automatic logic exp_err();
    foreach (mq[i]) if (mq[i][2:0] != 3'b000) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int lvl(input logic [1:0] s);
    case (s)
      2'b00: return 1;
      2'b01: return 4;
      2'b10: return 8;
      default: return 14;
    endcase
  endfunction

  // Drive one cycle of inputs, advance the model at the edge, release inputs 1ns later.
  task automatic step(input logic ps, input logic pp, input logic [10:0] d,
                      input logic fr, input logic rs);
    push = ps; pop = pp; data_in = d; fifo_reset = fr; reset_status = rs;
    @(posedge clk);
    model_step(ps, pp, d, fr, rs);
    #1;
    push = 1'b0; pop = 1'b0; data_in = '0; fifo_reset = 1'b0; reset_status = 1'b0;
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", empty); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", full); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b want 0", overrun); end
    n_checks++; if (error_bit !== 1'b0) begin n_fail++; $display("FAIL reset_error_bit got %b want 0", error_bit); end
    n_checks++; if (data_out !== 11'h000) begin n_fail++; $display("FAIL reset_data_out got %h want 000", data_out); end
    wb_rst_i = 1'b0;
    mq.delete(); movr = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    step(1'b1, 1'b0, 11'h208, 1'b0, 1'b0);
    n_checks++; if (count !== 5'd1) begin n_fail++; $display("FAIL basic_cnt1 got %0d want 1", count); end
    n_checks++; if (data_out !== 11'h208) begin n_fail++; $display("FAIL basic_head1 got %h want 208", data_out); end
    step(1'b1, 1'b0, 11'h210, 1'b0, 1'b0);
    n_checks++; if (count !== 5'd2) begin n_fail++; $display("FAIL basic_cnt2 got %0d want 2", count); end
    n_checks++; if (data_out !== 11'h208) begin n_fail++; $display("FAIL basic_head2 got %h want 208", data_out); end
    step(1'b0, 1'b1, 11'h000, 1'b0, 1'b0);
    n_checks++; if (count !== 5'd1) begin n_fail++; $display("FAIL basic_cnt3 got %0d want 1", count); end
    n_checks++; if (data_out !== 11'h210) begin n_fail++; $display("FAIL basic_head3 got %h want 210", data_out); end
    step(1'b0, 1'b1, 11'h000, 1'b0, 1'b0);
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL basic_cnt4 got %0d want 0", count); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL basic_empty got %b want 1", empty); end
    n_checks++; if (data_out !== 11'h000) begin n_fail++; $display("FAIL basic_head4 got %h want 000", data_out); end
    // Pop on empty is ignored.
    step(1'b0, 1'b1, 11'h000, 1'b0, 1'b0);
    n_checks++; if (count !== 5'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL basic_pop_empty cnt %0d empty %b want 0 1", count, empty); end
  endtask

  task automatic test_overrun();
    for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, 11'(i), 1'b0, 1'b0);
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_before got %b want 0", overrun); end
    step(1'b1, 1'b0, 11'd17, 1'b0, 1'b0);
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL ovr_full got %b want 1", full); end
    n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL ovr_count got %0d want 16", count); end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set got %b want 1", overrun); end
    // reset_status together with another push on full: set wins.
    step(1'b1, 1'b0, 11'd18, 1'b0, 1'b1);
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set_wins got %b want 1", overrun); end
    for (int i = 1; i <= 16; i++) begin
      n_checks++; if (data_out !== 11'(i)) begin n_fail++; $display("FAIL ovr_order[%0d] got %h want %h", i, data_out, 11'(i)); end
      step(1'b0, 1'b1, 11'h000, 1'b0, 1'b0);
    end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL ovr_drained got %b want 1", empty); end
    step(1'b0, 1'b0, 11'h000, 1'b0, 1'b1);
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear got %b want 0", overrun); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 11'h100 + 11'(i << 3), 1'b0, 1'b0);
    step(1'b1, 1'b1, 11'h3f8, 1'b0, 1'b0);
    n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL fpp_count got %0d want 16", count); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL fpp_overrun got %b want 0", overrun); end
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fpp_full got %b want 1", full); end
    for (int i = 1; i <= 16; i++) begin
      logic [10:0] want;
      want = (i == 16) ? 11'h3f8 : 11'h100 + 11'(i << 3);
      n_checks++; if (data_out !== want) begin n_fail++; $display("FAIL fpp_order[%0d] got %h want %h", i, data_out, want); end
      step(1'b0, 1'b1, 11'h000, 1'b0, 1'b0);
    end
  endtask

  task automatic test_error_bit();
    n_checks++; if (error_bit !== 1'b0) begin n_fail++; $display("FAIL err_idle got %b want 0", error_bit); end
    step(1'b1, 1'b0, 11'h0a1, 1'b0, 1'b0);
    n_checks++; if (error_bit !== 1'b1) begin n_fail++; $display("FAIL err_push got %b want 1", error_bit); end
    step(1'b0, 1'b1, 11'h000, 1'b0, 1'b0);
    n_checks++; if (error_bit !== 1'b0) begin n_fail++; $display("FAIL err_pop got %b want 0", error_bit); end
    step(1'b1, 1'b0, 11'h0a1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 11'h004, 1'b0, 1'b0);
    step(1'b0, 1'b1, 11'h000, 1'b0, 1'b0);
    n_checks++; if (error_bit !== 1'b1) begin n_fail++; $display("FAIL err_two_one_left got %b want 1", error_bit); end
    step(1'b0, 1'b1, 11'h000, 1'b0, 1'b0);
    n_checks++; if (error_bit !== 1'b0) begin n_fail++; $display("FAIL err_two_gone got %b want 0", error_bit); end
  endtask

  task automatic test_flush();
    step(1'b1, 1'b0, 11'h108, 1'b0, 1'b0);
    step(1'b1, 1'b0, 11'h112, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 11'h200 + 11'(i << 3), 1'b0, 1'b0);
    n_checks++; if (count !== 5'd5 || error_bit !== 1'b1) begin n_fail++; $display("FAIL flush_setup cnt %0d err %b want 5 1", count, error_bit); end
    step(1'b1, 1'b0, 11'h7f8, 1'b1, 1'b0);
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL flush_count got %0d want 0", count); end
    n_checks++; if (error_bit !== 1'b0) begin n_fail++; $display("FAIL flush_err got %b want 0", error_bit); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL flush_ovr got %b want 0", overrun); end
    n_checks++; if (empty !== 1'b1 || data_out !== 11'h000) begin n_fail++; $display("FAIL flush_empty empty %b data %h want 1 000", empty, data_out); end
    step(1'b1, 1'b0, 11'h1e0, 1'b0, 1'b0);
    n_checks++; if (data_out !== 11'h1e0 || count !== 5'd1) begin n_fail++; $display("FAIL flush_after data %h cnt %0d want 1e0 1", data_out, count); end
    step(1'b0, 1'b1, 11'h000, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
`ifdef UART_RX_FIFO_TRIG_EN
    trig_sel = 2'b01;
`endif
    for (int i = 1; i <= 7; i++) begin
      step(1'b1, 1'b0, 11'(i << 3) | 11'(i == 3), 1'b0, 1'b0);
      n_checks++; if (count !== 5'(i)) begin n_fail++; $display("FAIL ar_count[%0d] got %0d want %0d", i, count, i); end
`ifdef UART_RX_FIFO_TRIG_EN
      n_checks++; if (trig_hit !== (i >= 4)) begin n_fail++; $display("FAIL ar_trig[%0d] got %b want %b", i, trig_hit, (i >= 4)); end
`endif
    end
    // Overrun not needed; assert reset mid-cycle, away from any clock edge.
    #2 wb_rst_i = 1'b1;
    #1;
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL ar_rst_count got %0d want 0", count); end
    n_checks++; if (empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL ar_rst_flags empty %b full %b want 1 0", empty, full); end
    n_checks++; if (error_bit !== 1'b0 || overrun !== 1'b0) begin n_fail++; $display("FAIL ar_rst_err err %b ovr %b want 0 0", error_bit, overrun); end
    n_checks++; if (data_out !== 11'h000) begin n_fail++; $display("FAIL ar_rst_data got %h want 000", data_out); end
`ifdef UART_RX_FIFO_TRIG_EN
    n_checks++; if (trig_hit !== 1'b0) begin n_fail++; $display("FAIL ar_rst_trig got %b want 0", trig_hit); end
`endif
    mq.delete(); movr = 1'b0;
    @(posedge clk); #1;
    wb_rst_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      logic ps, pp, fr, rs;
      logic [10:0] d;
      // Phases bias toward filling, draining, or mixing.
      case ((n / 100) % 3)
        0: begin ps = ($urandom_range(0, 9) < 8); pp = ($urandom_range(0, 9) < 2); end
        1: begin ps = ($urandom_range(0, 9) < 2); pp = ($urandom_range(0, 9) < 8); end
        default: begin ps = $urandom_range(0, 1) == 1; pp = $urandom_range(0, 1) == 1; end
      endcase
      fr = ($urandom_range(0, 79) == 0);
      rs = ($urandom_range(0, 9) == 0);
      d  = {8'($urandom), ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000};
`ifdef UART_RX_FIFO_TRIG_EN
      trig_sel = 2'($urandom_range(0, 3));
`endif
      step(ps, pp, d, fr, rs);
      n_checks++; if (count !== 5'(mq.size())) begin n_fail++; $display("FAIL rnd_count[%0d] got %0d want %0d", n, count, mq.size()); end
      n_checks++; if (data_out !== exp_head()) begin n_fail++; $display("FAIL rnd_data[%0d] got %h want %h", n, data_out, exp_head()); end
      n_checks++; if (full !== (mq.size() == DEPTH) || empty !== (mq.size() == 0)) begin n_fail++; $display("FAIL rnd_flags[%0d] full %b empty %b size %0d", n, full, empty, mq.size()); end
      n_checks++; if (overrun !== movr) begin n_fail++; $display("FAIL rnd_overrun[%0d] got %b want %b", n, overrun, movr); end
      n_checks++; if (error_bit !== exp_err()) begin n_fail++; $display("FAIL rnd_error_bit[%0d] got %b want %b", n, error_bit, exp_err()); end
`ifdef UART_RX_FIFO_TRIG_EN
      n_checks++; if (trig_hit !== (mq.size() >= lvl(trig_sel))) begin n_fail++; $display("FAIL rnd_trig[%0d] got %b want %b", n, trig_hit, (mq.size() >= lvl(trig_sel))); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_full_push_pop();
    test_error_bit();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
